// File: rtl/cic_decim_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cic_decim_pkg
// Purpose  : Shared types and helpers for the multi-channel CIC decimator.
//            - cic_width(): internal accumulator width, ORDER*OSR_WIDTH+DATA_WIDTH
//            - seq_state_t: comb sequencer states
//            - MAX_ORDER  : largest supported CIC order
// Revision : 1.0 - initial release
// ============================================================================
package cic_decim_pkg;

  localparam int MAX_ORDER = 5;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_t;

  // Bit growth of an order-N CIC at decimation R is N*log2(R); with
  // R up to 2**osr_w that is order*osr_w bits on top of the input width.
  function automatic int cic_width(input int order, input int osr_w, input int data_w);
    return order * osr_w + data_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cic_decim_mc_if.sv
`default_nettype none
// ============================================================================
// Module   : cic_decim_mc_if
// Purpose  : Sample-in / result-out bundle of the CIC decimator.
//   clock_ena  input-rate strobe
//   data       CHANNELS packed unsigned samples, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   osr        decimation ratio minus one
//   res/res_ch channel-tagged result, qualified by valid
//   overrun    pulse when a decimation point had to be dropped
//   master: drives samples; slave: the decimator
// Revision : 1.0 - initial release
// ============================================================================
interface cic_decim_mc_if #(
  parameter int CHANNELS   = 4,
  parameter int DATA_WIDTH = 10,
  parameter int OSR_WIDTH  = 7,
  parameter int RES_WIDTH  = 10
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                           clock_ena;
  logic [CHANNELS*DATA_WIDTH-1:0] data;
  logic [OSR_WIDTH-1:0]           osr;
  logic [RES_WIDTH-1:0]           res;
  logic [CH_W-1:0]                res_ch;
  logic                           valid;
  logic                           overrun;

  modport master (output clock_ena, data, osr, input res, res_ch, valid, overrun);
  modport slave  (input clock_ena, data, osr, output res, res_ch, valid, overrun);
endinterface
`default_nettype wire

// File: rtl/cic_integ_chain.sv
`default_nettype none
// ============================================================================
// Module   : cic_integ_chain
// Purpose  : ORDER cascaded integrators for one channel, advanced on i_ena.
//   clock, aclr_n (async, active low), sclr (sync clear)
//   i_ena    input-rate strobe
//   i_data   unsigned input sample
//   o_integ  last integrator (wraps modulo 2**WIDTH)
// Revision : 1.0 - initial release
// ============================================================================
module cic_integ_chain #(
  parameter int ORDER      = 3,
  parameter int DATA_WIDTH = 10,
  parameter int WIDTH      = 31
) (
  input  logic                  clock,
  input  logic                  aclr_n,
  input  logic                  sclr,
  input  logic                  i_ena,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [WIDTH-1:0]      o_integ
);

  logic [WIDTH-1:0] r_acc [ORDER];

  // Each stage adds the previous stage's pre-edge value, so the chain
  // behaves as ORDER integrators all clocked by the same strobe.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      for (int s = 0; s < ORDER; s++) r_acc[s] <= '0;
    end else if (sclr) begin
      for (int s = 0; s < ORDER; s++) r_acc[s] <= '0;
    end else if (i_ena) begin
      r_acc[0] <= r_acc[0] + WIDTH'(i_data);
      for (int s = 1; s < ORDER; s++) r_acc[s] <= r_acc[s] + r_acc[s-1];
    end
  end

  assign o_integ = r_acc[ORDER-1];

endmodule
`default_nettype wire

// File: rtl/cic_decim_mc.sv
`default_nettype none
// ============================================================================
// Module   : cic_decim_mc
// Purpose  : Multi-channel CIC decimator. Per-channel integrators run at the
//            input rate; one shared comb section is time-multiplexed over the
//            channels after each decimation point, producing a serial
//            channel-tagged result stream.
//   clock     system clock
//   aclr_n    asynchronous reset, active low
//   sclr      synchronous clear, same effect as reset
//   bus       cic_decim_mc_if.slave (clock_ena, data, osr -> res, res_ch,
//             valid, overrun)
// Options  : CIC_DECIM_ROUND_EN - round (with saturation) instead of truncate
// Revision : 1.0 - initial release
// ============================================================================
module cic_decim_mc
  import cic_decim_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int ORDER      = 3,
  parameter int DATA_WIDTH = 10,
  parameter int OSR_WIDTH  = 7,
  parameter int RES_WIDTH  = DATA_WIDTH
) (
  input logic          clock,
  input logic          aclr_n,
  input logic          sclr,
  cic_decim_mc_if.slave bus
);

  localparam int WIDTH   = cic_width(ORDER, OSR_WIDTH, DATA_WIDTH);
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PRIME_W = $clog2(MAX_ORDER + 1);

  // ---------------- integrators ----------------
  logic [WIDTH-1:0] w_integ [CHANNELS];

  generate
    for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
      cic_integ_chain #(
        .ORDER(ORDER), .DATA_WIDTH(DATA_WIDTH), .WIDTH(WIDTH)
      ) u_integ (
        .clock  (clock),
        .aclr_n (aclr_n),
        .sclr   (sclr),
        .i_ena  (bus.clock_ena),
        .i_data (bus.data[k*DATA_WIDTH +: DATA_WIDTH]),
        .o_integ(w_integ[k])
      );
    end
  endgenerate

  // ---------------- decimation counter ----------------
  logic [OSR_WIDTH-1:0] r_cnt, r_osr;
  logic                 w_hit;

  assign w_hit = bus.clock_ena && (r_cnt == r_osr);

  // osr is only taken at a decimation point, so a running period always
  // completes with the ratio it started with.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      r_cnt <= '0;
      r_osr <= '0;
    end else if (sclr) begin
      r_cnt <= '0;
      r_osr <= '0;
    end else if (bus.clock_ena) begin
      if (r_cnt == r_osr) begin
        r_cnt <= '0;
        r_osr <= bus.osr;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // ---------------- comb sequencer ----------------
  seq_state_t      r_state, w_state_nxt;
  logic [CH_W-1:0] r_idx, w_idx_nxt;
  logic            w_last, w_run, w_take, w_ovr;

  assign w_last = (r_idx == CH_W'(CHANNELS - 1));

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else if (sclr) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // A hit on the final RUN clock still counts as an overrun: IDLE is only
  // reached after that edge.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_run       = 1'b0;
    w_take      = 1'b0;
    w_ovr       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_hit) begin
          w_take      = 1'b1;
          w_state_nxt = RUN;
          w_idx_nxt   = '0;
        end
      end
      RUN: begin
        w_run = 1'b1;
        w_ovr = w_hit;
        if (w_last) begin
          w_state_nxt = IDLE;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // ---------------- snapshot ----------------
  logic [WIDTH-1:0] r_snap [CHANNELS];

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      for (int k = 0; k < CHANNELS; k++) r_snap[k] <= '0;
    end else if (sclr) begin
      for (int k = 0; k < CHANNELS; k++) r_snap[k] <= '0;
    end else if (w_take) begin
      for (int k = 0; k < CHANNELS; k++) r_snap[k] <= w_integ[k];
    end
  end

  // ---------------- shared comb section ----------------
  logic [WIDTH-1:0]     r_dly [CHANNELS][ORDER];
  logic [WIDTH-1:0]     w_din [ORDER];
  logic [RES_WIDTH-1:0] w_top, w_res;

  // w_din[s] is the input of comb stage s, which becomes that stage's
  // new delay value for the channel being served.
  always_comb begin
    logic [WIDTH-1:0] v;
    v = r_snap[r_idx];
    for (int s = 0; s < ORDER; s++) begin
      w_din[s] = v;
      v        = v - r_dly[r_idx][s];
    end
    w_top = v[WIDTH-1 -: RES_WIDTH];
  end

`ifdef CIC_DECIM_ROUND_EN
  localparam int HALF_IDX = (WIDTH > RES_WIDTH) ? (WIDTH - RES_WIDTH - 1) : 0;
  logic               w_half;
  logic [RES_WIDTH:0] w_sum;

  // Adding half an output LSB only carries into the kept bits when the
  // bit just below them is set, so the add is done on the top bits alone.
  always_comb begin
    logic [WIDTH-1:0] v;
    v = r_snap[r_idx];
    for (int s = 0; s < ORDER; s++) v = v - r_dly[r_idx][s];
    w_half = (WIDTH > RES_WIDTH) ? v[HALF_IDX] : 1'b0;
  end

  assign w_sum = {1'b0, w_top} + (RES_WIDTH + 1)'(w_half);
  assign w_res = w_sum[RES_WIDTH] ? {RES_WIDTH{1'b1}} : w_sum[RES_WIDTH-1:0];
`else
  assign w_res = w_top;
`endif

  // ---------------- comb history, priming and outputs ----------------
  logic [RES_WIDTH-1:0] r_res;
  logic [CH_W-1:0]      r_res_ch;
  logic                 r_valid, r_overrun;
  logic [PRIME_W-1:0]   r_prime;

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      for (int k = 0; k < CHANNELS; k++)
        for (int s = 0; s < ORDER; s++) r_dly[k][s] <= '0;
      r_res     <= '0;
      r_res_ch  <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
      r_prime   <= '0;
    end else if (sclr) begin
      for (int k = 0; k < CHANNELS; k++)
        for (int s = 0; s < ORDER; s++) r_dly[k][s] <= '0;
      r_res     <= '0;
      r_res_ch  <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
      r_prime   <= '0;
    end else begin
      r_overrun <= w_ovr;
      r_valid   <= 1'b0;
      if (w_run) begin
        for (int s = 0; s < ORDER; s++) r_dly[r_idx][s] <= w_din[s];
        r_res    <= w_res;
        r_res_ch <= r_idx;
        // Comb delays start at zero, so the first ORDER snapshots only
        // fill the history.
        r_valid  <= (r_prime == PRIME_W'(ORDER));
        if (w_last && (r_prime != PRIME_W'(ORDER))) r_prime <= r_prime + 1'b1;
      end
    end
  end

  assign bus.res     = r_res;
  assign bus.res_ch  = r_res_ch;
  assign bus.valid   = r_valid;
  assign bus.overrun = r_overrun;

endmodule
`default_nettype wire
